// File: rtl/fwd_hazard_scoreboard_if.sv
// Decode/execute-side bundle for the forwarding and hazard scoreboard.
// master drives pipeline state in; slave is the scoreboard block.
interface fwd_hazard_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  logic                      exmem_reg_write;
  logic [REG_AW-1:0]         exmem_rd;
  logic                      memwb_reg_write;
  logic [REG_AW-1:0]         memwb_rd;
  logic                      mc_done;
  logic [REG_AW-1:0]         mc_done_rd;
  logic [NUM_SRC*REG_AW-1:0] idex_rs;
  logic [NUM_SRC-1:0]        idex_rs_used;
  logic                      idex_valid;
  logic                      idex_is_load;
  logic [REG_AW-1:0]         idex_rd;
  logic [NUM_SRC*REG_AW-1:0] ifid_rs;
  logic [NUM_SRC-1:0]        ifid_rs_used;
  logic                      ifid_reg_write;
  logic [REG_AW-1:0]         ifid_rd;
  logic                      mc_issue;
  logic [REG_AW-1:0]         mc_rd;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic [1:0]                stall_reason;
  logic [NUM_REGS-1:0]       pending;
  logic [CNT_W-1:0]          stall_cycles;
  logic                      sb_timeout;

  modport master (
    output exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
           mc_done, mc_done_rd, idex_rs, idex_rs_used, idex_valid,
           idex_is_load, idex_rd, ifid_rs, ifid_rs_used, ifid_reg_write,
           ifid_rd, mc_issue, mc_rd,
    input  fwd_sel, stall, stall_reason, pending, stall_cycles, sb_timeout
  );

  modport slave (
    input  exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
           mc_done, mc_done_rd, idex_rs, idex_rs_used, idex_valid,
           idex_is_load, idex_rd, ifid_rs, ifid_rs_used, ifid_reg_write,
           ifid_rd, mc_issue, mc_rd,
    output fwd_sel, stall, stall_reason, pending, stall_cycles, sb_timeout
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding selects, load-use / multicycle scoreboard stall,
// pending-register bitmap, stall counter and scoreboard-stall watchdog.
module fwd_hazard_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fwd_hazard_scoreboard_if.slave bus
);
  localparam int unsigned NUM_REGS = 2 ** REG_AW;
  localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);

  logic [NUM_REGS-1:0]  r_pending;
  logic [CNT_W-1:0]     r_stall_cycles;
  logic                 r_sb_timeout;
  logic [WD_W-1:0]      r_wd_cnt;

  logic [2*NUM_SRC-1:0] w_fwd_sel;
  logic                 w_load_use;
  logic                 w_raw;
  logic                 w_waw;
  logic                 w_sb_haz;
  logic                 w_stall;
  logic [NUM_REGS-1:0]  w_pending_nxt;

  // Per-source bypass select: EX/MEM over MEM/WB over multicycle writeback.
  always_comb begin
    w_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.idex_rs_used[i] && (bus.idex_rs[i*REG_AW +: REG_AW] != '0)) begin
        if (bus.exmem_reg_write && (bus.exmem_rd == bus.idex_rs[i*REG_AW +: REG_AW]))
          w_fwd_sel[2*i +: 2] = 2'b10;
        else if (bus.memwb_reg_write && (bus.memwb_rd == bus.idex_rs[i*REG_AW +: REG_AW]))
          w_fwd_sel[2*i +: 2] = 2'b01;
        else if (bus.mc_done && (bus.mc_done_rd == bus.idex_rs[i*REG_AW +: REG_AW]))
          w_fwd_sel[2*i +: 2] = 2'b11;
      end
    end
  end

  // Hazards on the decode instruction; scoreboard looks only at registered pending.
  always_comb begin
    w_load_use = 1'b0;
    w_raw      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.ifid_rs_used[i]) begin
        if (bus.idex_valid && bus.idex_is_load && (bus.idex_rd != '0) &&
            (bus.idex_rd == bus.ifid_rs[i*REG_AW +: REG_AW]))
          w_load_use = 1'b1;
        if ((bus.ifid_rs[i*REG_AW +: REG_AW] != '0) &&
            r_pending[bus.ifid_rs[i*REG_AW +: REG_AW]])
          w_raw = 1'b1;
      end
    end
    w_waw    = bus.ifid_reg_write && (bus.ifid_rd != '0) && r_pending[bus.ifid_rd];
    w_sb_haz = w_raw || w_waw;
    w_stall  = w_load_use || w_sb_haz;
  end

  // Completion clears, issue sets; set applied last so it wins on a collision.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.mc_done)
      w_pending_nxt[bus.mc_done_rd] = 1'b0;
    if (bus.mc_issue && (bus.mc_rd != '0))
      w_pending_nxt[bus.mc_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= '0;
      r_stall_cycles <= '0;
      r_sb_timeout   <= 1'b0;
      r_wd_cnt       <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_sb_haz) begin
        if (r_wd_cnt != WD_W'(TIMEOUT))
          r_wd_cnt <= r_wd_cnt + WD_W'(1);
        if (r_wd_cnt >= WD_W'(TIMEOUT - 1))
          r_sb_timeout <= 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign bus.fwd_sel      = w_fwd_sel;
  assign bus.stall        = w_stall;
  assign bus.stall_reason = {w_sb_haz, w_load_use};
  assign bus.pending      = r_pending;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.sb_timeout   = r_sb_timeout;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with NUM_SRC=3, TIMEOUT=8.
module tb_fwd_hazard_scoreboard;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fwd_hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .CNT_W(CNT_W)) u_if ();

  fwd_hazard_scoreboard #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.exmem_reg_write = 1'b0; u_if.exmem_rd   = '0;
    u_if.memwb_reg_write = 1'b0; u_if.memwb_rd   = '0;
    u_if.mc_done         = 1'b0; u_if.mc_done_rd = '0;
    u_if.idex_rs         = '0;   u_if.idex_rs_used = '0;
    u_if.idex_valid      = 1'b0; u_if.idex_is_load = 1'b0;
    u_if.idex_rd         = '0;
    u_if.ifid_rs         = '0;   u_if.ifid_rs_used = '0;
    u_if.ifid_reg_write  = 1'b0; u_if.ifid_rd    = '0;
    u_if.mc_issue        = 1'b0; u_if.mc_rd      = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pending", 64'(u_if.pending), 64'd0);
    chk("rst_sb_timeout", 64'(u_if.sb_timeout), 64'd0);
    chk("rst_stall_cycles", 64'(u_if.stall_cycles), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();
    #3;
    pulse_reset();

    // Forwarding priority: rs0=5, rs1=5, rs2=0
    u_if.exmem_reg_write = 1'b1; u_if.exmem_rd = 5'd5;
    u_if.memwb_reg_write = 1'b1; u_if.memwb_rd = 5'd5;
    u_if.idex_rs      = {5'd0, 5'd5, 5'd5};
    u_if.idex_rs_used = 3'b111;
    #1 chk("fwd_exmem", 64'(u_if.fwd_sel), 64'(6'b00_10_10));
    u_if.exmem_reg_write = 1'b0;
    #1 chk("fwd_memwb", 64'(u_if.fwd_sel), 64'(6'b00_01_01));
    u_if.idex_rs_used = 3'b110;
    #1 chk("fwd_unused", 64'(u_if.fwd_sel), 64'(6'b00_01_00));
    clear_inputs();

    // Multicycle bypass, then MEM/WB takes priority
    u_if.mc_done = 1'b1; u_if.mc_done_rd = 5'd7;
    u_if.idex_rs = {5'd0, 5'd0, 5'd7}; u_if.idex_rs_used = 3'b001;
    #1 chk("fwd_mc", 64'(u_if.fwd_sel), 64'(6'b00_00_11));
    u_if.memwb_reg_write = 1'b1; u_if.memwb_rd = 5'd7;
    #1 chk("fwd_mc_memwb", 64'(u_if.fwd_sel), 64'(6'b00_00_01));
    clear_inputs();
    u_if.exmem_reg_write = 1'b1; u_if.exmem_rd = 5'd0; u_if.idex_rs_used = 3'b111;
    #1 chk("fwd_r0", 64'(u_if.fwd_sel), 64'd0);
    clear_inputs();

    // Load-use
    u_if.idex_valid = 1'b1; u_if.idex_is_load = 1'b1; u_if.idex_rd = 5'd3;
    u_if.ifid_rs = {5'd0, 5'd0, 5'd3}; u_if.ifid_rs_used = 3'b001;
    #1 chk("lu_stall", 64'(u_if.stall), 64'd1);
    chk("lu_reason", 64'(u_if.stall_reason), 64'(2'b01));
    u_if.ifid_rs_used = 3'b000;
    #1 chk("lu_unused", 64'(u_if.stall), 64'd0);
    u_if.ifid_rs_used = 3'b001; u_if.idex_is_load = 1'b0;
    #1 chk("lu_not_load", 64'(u_if.stall), 64'd0);
    clear_inputs();
    #1;

    // Scoreboard RAW on r9: issue cycle 0, complete cycle 4
    @(negedge clk);
    pulse_reset();
    u_if.mc_issue = 1'b1; u_if.mc_rd = 5'd9;
    u_if.ifid_rs = {5'd0, 5'd9, 5'd0};
    #1 chk("sb_c0_stall", 64'(u_if.stall), 64'd0);
    tick();
    u_if.mc_issue = 1'b0; u_if.mc_rd = '0; u_if.ifid_rs_used = 3'b010;
    #1 chk("sb_c1_pending", 64'(u_if.pending[9]), 64'd1);
    chk("sb_c1_reason", 64'(u_if.stall_reason), 64'(2'b10));
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("sb_c%0d_stall", c), 64'(u_if.stall), 64'd1);
    end
    u_if.mc_done = 1'b1; u_if.mc_done_rd = 5'd9;
    #1 chk("sb_c4_still_stall", 64'(u_if.stall), 64'd1);
    tick();
    u_if.mc_done = 1'b0;
    #1 chk("sb_c5_stall", 64'(u_if.stall), 64'd0);
    chk("sb_c5_pending", 64'(u_if.pending), 64'd0);
    chk("sb_stall_cycles", 64'(u_if.stall_cycles), 64'd4);
    chk("sb_no_timeout", 64'(u_if.sb_timeout), 64'd0);
    clear_inputs();

    // Issue and done on the same edge: set wins; r0 never pending
    u_if.mc_issue = 1'b1; u_if.mc_rd = 5'd9;
    tick();
    u_if.mc_done = 1'b1; u_if.mc_done_rd = 5'd9;
    tick();
    clear_inputs();
    #1 chk("collide_pending", 64'(u_if.pending), 64'(32'h0000_0200));
    u_if.ifid_reg_write = 1'b1; u_if.ifid_rd = 5'd9;
    #1 chk("waw_reason", 64'(u_if.stall_reason), 64'(2'b10));
    u_if.ifid_reg_write = 1'b0;
    u_if.mc_issue = 1'b1; u_if.mc_rd = 5'd0;
    u_if.mc_done = 1'b1; u_if.mc_done_rd = 5'd9;
    tick();
    clear_inputs();
    #1 chk("r0_never_pending", 64'(u_if.pending), 64'd0);

    // Watchdog: RAW held on r12
    u_if.mc_issue = 1'b1; u_if.mc_rd = 5'd12;
    tick();
    clear_inputs();
    u_if.ifid_rs = {5'd0, 5'd0, 5'd12}; u_if.ifid_rs_used = 3'b001;
    for (int c = 1; c <= 7; c++) tick();
    chk("wd_before", 64'(u_if.sb_timeout), 64'd0);
    tick();
    chk("wd_fired", 64'(u_if.sb_timeout), 64'd1);
    chk("wd_stall_kept", 64'(u_if.stall), 64'd1);
    u_if.ifid_rs_used = 3'b000;
    tick();
    chk("wd_sticky", 64'(u_if.sb_timeout), 64'd1);
    chk("wd_no_stall", 64'(u_if.stall), 64'd0);
    @(negedge clk);
    pulse_reset();
    u_if.mc_done = 1'b1; u_if.mc_done_rd = 5'd12;
    tick();
    clear_inputs();
    #1 chk("late_done_noop", 64'(u_if.pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
Parametrised successor to the 2-operand pipeline forwarding unit. Generates forwarding selects for NUM_SRC execute-stage operands, including a bypass from a variable-latency (multicycle) functional unit. Detects load-use and scoreboard (RAW/WAW on multicycle results) hazards and issues the stall. Keeps per-register pending state, a stall performance counter and a scoreboard-stall watchdog. Sits between decode and the ID/EX and EX/MEM pipeline registers.

Parameters:
NUM_SRC, 2, source operands per instruction (1..4)
REG_AW, 5, register address width; NUM_REGS = 2**REG_AW
CNT_W, 32, width of stall_cycles counter
TIMEOUT, 256, consecutive scoreboard-stall cycles before sb_timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
exmem_reg_write  in  1  EX/MEM writes rd
exmem_rd  in  REG_AW  EX/MEM destination
memwb_reg_write  in  1  MEM/WB writes rd
memwb_rd  in  REG_AW  MEM/WB destination
mc_done  in  1  multicycle unit writes result this cycle
mc_done_rd  in  REG_AW  multicycle result destination
idex_rs  in  NUM_SRC*REG_AW  EX-stage sources, source i at [i*REG_AW +: REG_AW]
idex_rs_used  in  NUM_SRC  source i read by EX instruction
idex_valid  in  1  ID/EX holds a valid instruction
idex_is_load  in  1  EX instruction is a load
idex_rd  in  REG_AW  EX destination
ifid_rs  in  NUM_SRC*REG_AW  decode-stage sources
ifid_rs_used  in  NUM_SRC  decode source i used
ifid_reg_write  in  1  decode instruction writes ifid_rd
ifid_rd  in  REG_AW  decode destination
mc_issue  in  1  multicycle op leaves ID/EX this cycle
mc_rd  in  REG_AW  destination of issued multicycle op
fwd_sel  out  2*NUM_SRC  per-source select, source i at [2i +: 2]
stall  out  1  freeze IF/ID, bubble ID/EX
stall_reason  out  2  bit0 load-use, bit1 scoreboard
pending  out  NUM_REGS  scoreboard bitmap
stall_cycles  out  CNT_W  saturating count of stalled cycles
sb_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, stall_cycles=0, sb_timeout=0, internal watchdog counter=0. Combinational outputs follow inputs with pending=0.
- fwd_sel[i], combinational: 00 if !idex_rs_used[i] or rs==0. Otherwise, first match in priority order: 10 EX/MEM (exmem_reg_write, exmem_rd==rs); 01 MEM/WB (memwb_reg_write, memwb_rd==rs); 11 multicycle (mc_done, mc_done_rd==rs); else 00.
- Load-use hazard, combinational: idex_valid & idex_is_load & idex_rd!=0, and idex_rd equals any used ifid_rs. Sets stall_reason[0].
- Scoreboard hazard, combinational: any used ifid_rs!=0 with pending bit set (RAW), or ifid_reg_write & ifid_rd!=0 with pending[ifid_rd] set (WAW). Sets stall_reason[1].
- Scoreboard hazard uses registered pending only. A register cleared by mc_done in cycle N stalls through N and releases in N+1. The register file is written in N.
- stall = |stall_reason.
- pending update, per clock edge:
  - mc_done clears bit mc_done_rd.
  - mc_issue with mc_rd!=0 sets bit mc_rd.
  - Same register in both: set wins.
  - Bit 0 is never set.
- stall_cycles increments on every stall=1 cycle and saturates at all-ones.
- Watchdog: counts consecutive cycles with stall_reason[1]=1; resets to 0 on any cycle without it. On reaching TIMEOUT, sb_timeout goes 1 the next edge and stays 1 until reset. Stall behaviour is unchanged.
- Reset mid-operation clears pending immediately. A later mc_done for a cleared register is a no-op.
- No state in fwd_sel path: zero-cycle latency.

Test Plan:
- NUM_SRC=3; exmem_rd=5 write, memwb_rd=5 write, idex_rs={5,5,0} all used -> fwd_sel={00,10,10}. Drop exmem_reg_write -> {00,01,01}.
- mc_done, mc_done_rd=7, idex_rs0=7, no EX/MEM or MEM/WB match -> fwd_sel[1:0]=11. Add memwb_rd=7 -> 01.
- idex_valid, idex_is_load, idex_rd=3, ifid_rs0=3 used -> stall=1, stall_reason=01. ifid_rs0=3 unused -> stall=0.
- mc_issue rd=9 at cycle 0, ifid_rs1=9 used from cycle 1, mc_done rd=9 at cycle 4 -> pending[9]=1 cycles 1-4, stall=1 cycles 1-4, stall=0 cycle 5, stall_cycles=4.
- Same edge: mc_issue rd=9 and mc_done rd=9 -> pending[9] stays 1. ifid_reg_write ifid_rd=9 -> stall_reason=10 (WAW).
- TIMEOUT=8; hold RAW on pending reg 12 for 8 cycles -> sb_timeout=1 after the 8th edge. Clear the hazard -> sb_timeout stays 1. Pulse rst_n low -> sb_timeout=0, pending=0.
